snoop_inval_unit: RTL and testbench
===================================

SNOOP_INVAL_UNIT -- requirements
Module: snoop_inval_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning snoop queue entries; the value is a power of 2 and at least 2.
REQ-002 SHALL have parameter WAYS, default 2, meaning dcache associativity.
REQ-003 SHALL have parameter IDX_W, default 6, meaning dcache set-index width.
REQ-004 SHALL have parameter OFFSET_W, default 4, meaning line-offset width; TAG_W = 32-IDX_W-OFFSET_W.
REQ-005 SHALL have port: clk  in  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port: snoop_valid  in  1  remote-core store snoop, one address per cycle; it has no backpressure.
REQ-008 SHALL have port: snoop_addr  in  32  byte address of the remote store.
REQ-009 SHALL have port: tag_req  out  1  request for the dcache tag read port.
REQ-010 SHALL have port: tag_idx  out  IDX_W  set index for the tag read.
REQ-011 SHALL have port: tag_gnt  in  1  grant; local accesses have priority.
REQ-012 SHALL have port: tag_rdata  in  WAYS*(TAG_W+1)  per way {valid,tag}, valid the cycle after the grant.
REQ-013 SHALL have port: inv_we  out  WAYS  way mask for the valid-bit clear.
REQ-014 SHALL have port: inv_idx  out  IDX_W  set index for the clear.
REQ-015 SHALL have port: busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-016 SHALL have port: overflow  out  1  sticky flag set when a snoop was dropped.

Function
REQ-017 SHALL push snoop_addr[31:OFFSET_W] into the FIFO on snoop_valid when the FIFO is not full, or when a pop occurs in the same cycle.
REQ-018 SHALL drop the snoop and set overflow when the FIFO is full with no same-cycle pop; overflow clears only on reset.
REQ-019 SHALL implement FSM states IDLE, REQ, CMP and INV.
REQ-020 SHALL go IDLE->REQ when the FIFO is non-empty; a push into an empty FIFO is visible to IDLE on the next cycle.
REQ-021 SHALL, in REQ, hold tag_req=1 with tag_idx taken from the head entry until tag_gnt=1, then go to CMP.
REQ-022 SHALL, in CMP, compute hit[w] = valid[w] AND tag[w]==head tag; any hit goes to INV, and no hit pops the head and goes to IDLE.
REQ-023 SHALL, in INV, drive inv_we=hit mask (multiple ways allowed) and inv_idx=head index for exactly one cycle, pop the head, and go to IDLE.
REQ-024 SHALL give a hit, with an immediate grant, an invalidate 3 cycles after leaving IDLE (REQ, CMP, INV).
REQ-025 SHALL drive inv_we=0 and tag_req=0 in all states other than INV and REQ respectively.
REQ-026 SHALL keep the head entry stable from REQ until its pop.
REQ-027 SHALL process FIFO entries strictly in order and wrap the FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, on rst low, asynchronously set FSM=IDLE, FIFO empty, overflow=0, tag_req=0, inv_we=0, busy=0 and tag_idx=inv_idx=0.
REQ-029 SHALL discard any in-flight snoop on reset mid-operation and issue no partial invalidate.

Configuration
REQ-030 SHALL, with SNOOP_COALESCE_EN defined, drop an incoming snoop whose line address equals the most recently pushed entry still in the FIFO, without setting overflow.
REQ-031 SHALL, without SNOOP_COALESCE_EN, enqueue every snoop, duplicates included.

Structure
REQ-032 SHALL declare snoop_state_t and snoop_line_addr_t in taiga_types, and the FIFO_DEPTH default in taiga_config.
REQ-033 SHALL implement the queue as sub-module snoop_addr_fifo, parameterised by width and depth, with push/pop/full/empty outputs.

Verification
REQ-034 SHALL cover: snoop 0x0000_1230, way1 holds the tag, gnt immediate -> inv_we=2'b10, inv_idx=0x23, three cycles after leaving IDLE.
REQ-035 SHALL cover: snoop that misses in both ways -> no inv_we pulse, FIFO empties, busy=0 after CMP.
REQ-036 SHALL cover: tag_gnt held low for 5 cycles -> tag_req stays high for 5 cycles, then the invalidate proceeds correctly.
REQ-037 SHALL cover: 6 back-to-back snoops with gnt low, FIFO_DEPTH=4 -> 4 queued, overflow=1, the 4 processed in order.
REQ-038 SHALL cover: push while full in the same cycle as the INV pop -> new entry accepted, overflow stays 0.
REQ-039 SHALL cover: with SNOOP_COALESCE_EN, two snoops to 0x40 then 0x44 -> one queued entry, one lookup.

Source files
------------

// File: rtl/taiga_config.sv
// Build-time defaults for the snoop invalidation path.
package taiga_config;

  localparam int SNOOP_FIFO_DEPTH = 4;
  localparam int SNOOP_OFFSET_W   = 4;

endpackage

// File: rtl/taiga_types.sv
// Shared types for the snoop invalidation path.
package taiga_types;

  import taiga_config::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CMP  = 2'd2,
    INV  = 2'd3
  } snoop_state_t;

  // Line address (byte address without the line offset) for the default geometry.
  typedef logic [31-SNOOP_OFFSET_W:0] snoop_line_addr_t;

endpackage

// File: rtl/snoop_inval_unit_if.sv
// Bus bundle between the snoop invalidation unit and its environment.
// Handshakes: snoop_valid is a one-cycle push with no backpressure.
// tag_req is held with a stable tag_idx until tag_gnt is high at a rising
// edge; tag_rdata is valid the cycle after that grant. inv_we is a one-cycle
// strobe qualified by inv_idx.
interface snoop_inval_unit_if
  import taiga_types::*;
#(
  parameter int WAYS     = 2,
  parameter int IDX_W    = 6,
  parameter int OFFSET_W = 4
);

  localparam int TAG_W = 32 - IDX_W - OFFSET_W;

  logic                      snoop_valid;
  logic [31:0]               snoop_addr;
  logic                      tag_req;
  logic [IDX_W-1:0]          tag_idx;
  logic                      tag_gnt;
  logic [WAYS*(TAG_W+1)-1:0] tag_rdata;
  logic [WAYS-1:0]           inv_we;
  logic [IDX_W-1:0]          inv_idx;
  logic                      busy;
  logic                      overflow;
  snoop_state_t              dbg_state;

  modport slave (
    input  snoop_valid, snoop_addr, tag_gnt, tag_rdata,
    output tag_req, tag_idx, inv_we, inv_idx, busy, overflow, dbg_state
  );

  modport master (
    output snoop_valid, snoop_addr, tag_gnt, tag_rdata,
    input  tag_req, tag_idx, inv_we, inv_idx, busy, overflow, dbg_state
  );

endinterface

// File: rtl/snoop_addr_fifo.sv
// Power-of-two FIFO holding pending snoop line addresses.
// With SNOOP_COALESCE_EN defined it also exposes the most recently pushed
// entry and whether that entry survives the current cycle's pop.
module snoop_addr_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
`ifdef SNOOP_COALESCE_EN
  output logic [WIDTH-1:0] last,
  output logic             last_valid,
`endif
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

`ifdef SNOOP_COALESCE_EN
  logic [AW-1:0] tail_idx;
  assign tail_idx   = wr_ptr[AW-1:0] - AW'(1);
  assign last       = mem[tail_idx];
  // A sole entry being popped this cycle no longer counts as queued.
  assign last_valid = !empty && !(pop && ((wr_ptr - rd_ptr) == (AW+1)'(1)));
`endif

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/snoop_inval_unit.sv
// Snoop invalidation unit: queues remote-store line addresses, looks each
// one up in the dcache tags and clears the valid bit of every matching way.
// Optional feature macro: SNOOP_COALESCE_EN (drop a snoop that repeats the
// most recently queued line).
module snoop_inval_unit
  import taiga_types::*, taiga_config::*;
#(
  parameter int FIFO_DEPTH = SNOOP_FIFO_DEPTH,
  parameter int WAYS       = 2,
  parameter int IDX_W      = 6,
  parameter int OFFSET_W   = 4
) (
  input logic                clk,
  input logic                rst,
  snoop_inval_unit_if.slave  bus
);

  localparam int TAG_W  = 32 - IDX_W - OFFSET_W;
  localparam int LINE_W = 32 - OFFSET_W;
  localparam int ENT_W  = TAG_W + 1;

  snoop_state_t      state_q, state_d;
  logic [LINE_W-1:0] line_in, head;
  logic [IDX_W-1:0]  head_idx;
  logic [TAG_W-1:0]  head_tag;
  logic              full, empty, push, pop, dup;
  logic [WAYS-1:0]   hit, hit_q;
  logic              overflow_q;
  logic              unused_offset;

  assign line_in       = bus.snoop_addr[31:OFFSET_W];
  assign unused_offset = ^bus.snoop_addr[OFFSET_W-1:0];
  assign head_idx      = head[IDX_W-1:0];
  assign head_tag      = head[LINE_W-1:IDX_W];

`ifdef SNOOP_COALESCE_EN
  logic [LINE_W-1:0] last;
  logic              last_valid;
  assign dup = bus.snoop_valid && last_valid && (last == line_in);
`else
  assign dup = 1'b0;
`endif

  // A full queue still accepts when the head leaves in the same cycle.
  assign push = bus.snoop_valid && !dup && (!full || pop);

  snoop_addr_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .din        (line_in),
    .head       (head),
`ifdef SNOOP_COALESCE_EN
    .last       (last),
    .last_valid (last_valid),
`endif
    .full       (full),
    .empty      (empty)
  );

  // Sticky record of any snoop lost to a full queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else if (bus.snoop_valid && !dup && full && !pop) overflow_q <= 1'b1;
  end

  // Per-way tag match against the head entry; meaningful only in CMP.
  always_comb begin
    hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit[w] = bus.tag_rdata[w*ENT_W + TAG_W] &&
               (bus.tag_rdata[w*ENT_W +: TAG_W] == head_tag);
    end
  end

  // State register and the hit mask captured for the INV cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CMP) hit_q <= hit;
    end
  end

  // Next state, tag-port request, invalidate strobe and queue pop.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    bus.tag_req = 1'b0;
    bus.tag_idx = '0;
    bus.inv_we  = '0;
    bus.inv_idx = '0;
    unique case (state_q)
      IDLE: if (!empty) state_d = REQ;
      REQ: begin
        bus.tag_req = 1'b1;
        bus.tag_idx = head_idx;
        if (bus.tag_gnt) state_d = CMP;
      end
      CMP: begin
        if (|hit) begin
          state_d = INV;
        end else begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      INV: begin
        bus.inv_we  = hit_q;
        bus.inv_idx = head_idx;
        pop         = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = !empty || (state_q != IDLE);
  assign bus.overflow  = overflow_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_snoop_inval_unit.sv
// Self-checking bench for snoop_inval_unit. The environment plays the dcache
// (tag array model that responds to granted lookups and forgets invalidated
// ways); a transaction-level model predicts queue contents and outputs.
// Build with SNOOP_COALESCE_EN defined to exercise duplicate coalescing.
module tb_snoop_inval_unit;

  import taiga_types::*;

  localparam int DEPTH    = 4;
  localparam int WAYS     = 2;
  localparam int IDX_W    = 6;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = 32 - IDX_W - OFFSET_W;
  localparam int LINE_W   = 32 - OFFSET_W;
  localparam int RD_W     = WAYS * (TAG_W + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snoop_inval_unit_if #(.WAYS(WAYS), .IDX_W(IDX_W), .OFFSET_W(OFFSET_W)) bus ();

  snoop_inval_unit #(
    .FIFO_DEPTH (DEPTH),
    .WAYS       (WAYS),
    .IDX_W      (IDX_W),
    .OFFSET_W   (OFFSET_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard / model state ----------------
  logic [LINE_W-1:0] exp_q[$];
  logic [IDX_W-1:0]  grant_idx_q[$];
  logic [TAG_W-1:0]  ctag   [64][WAYS];
  bit                cvalid [64][WAYS];
  bit                m_req, m_rd, m_inv, m_ovf;
  logic [WAYS-1:0]   m_mask;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_lookups, req_wait, inv_cnt, first_req_cyc, inv_cyc;
  logic [WAYS-1:0]   inv_val;
  logic [IDX_W-1:0]  inv_idx_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [RD_W-1:0] rdata_for(input logic [IDX_W-1:0] i);
    logic [RD_W-1:0] r;
    r = '0;
    for (int w = 0; w < WAYS; w++) r[w*(TAG_W+1) +: TAG_W+1] = {cvalid[i][w], ctag[i][w]};
    return r;
  endfunction

  function automatic logic [WAYS-1:0] cache_mask(input logic [LINE_W-1:0] line);
    logic [WAYS-1:0] m;
    m = '0;
    for (int w = 0; w < WAYS; w++)
      m[w] = cvalid[line[IDX_W-1:0]][w] && (ctag[line[IDX_W-1:0]][w] == line[LINE_W-1:IDX_W]);
    return m;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [TAG_W-1:0] t;
    logic [IDX_W-1:0] i;
    logic [3:0]       o;
    t = TAG_W'($urandom_range(0, 3));
    i = IDX_W'($urandom_range(0, 15));
    o = 4'($urandom_range(0, 15));
    return {t, i, o};
  endfunction

  task automatic clear_cache();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < WAYS; w++) begin
        ctag[s][w]   = '0;
        cvalid[s][w] = 1'b0;
      end
  endtask

  task automatic random_cache();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < WAYS; w++) begin
        ctag[s][w]   = TAG_W'($urandom_range(0, 3));
        cvalid[s][w] = 1'($urandom_range(0, 1));
      end
  endtask

  task automatic clear_stats();
    n_lookups = 0; req_wait = 0; inv_cnt = 0; first_req_cyc = -1; inv_cyc = -1;
    inv_val = '0; inv_idx_val = '0;
    grant_idx_q.delete();
  endtask

  task automatic do_reset();
    bus.snoop_valid = 1'b0;
    bus.tag_gnt     = 1'b0;
    rst = 1'b0;
    #2;
    check("rst_tag_req",  bus.tag_req,  0);
    check("rst_tag_idx",  bus.tag_idx,  0);
    check("rst_inv_we",   bus.inv_we,   0);
    check("rst_inv_idx",  bus.inv_idx,  0);
    check("rst_busy",     bus.busy,     0);
    check("rst_overflow", bus.overflow, 0);
    exp_q.delete();
    m_req = 0; m_rd = 0; m_inv = 0; m_ovf = 0; m_mask = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ---------------- driver + per-cycle model ----------------
  task automatic step(input bit v, input logic [31:0] a, input bit g);
    logic [LINE_W-1:0] line, hd;
    logic [WAYS-1:0]   rd_mask;
    bit pop, dup, remain, pre_req, pre_rd, pre_inv;
    int sz0;
    hd = (exp_q.size() != 0) ? exp_q[0] : '0;
    bus.snoop_valid = v;
    bus.snoop_addr  = a;
    bus.tag_gnt     = g;
    bus.tag_rdata   = m_rd ? rdata_for(hd[IDX_W-1:0]) : RD_W'({$urandom(), $urandom()});
    @(negedge clk);
    check("tag_req",  bus.tag_req,  m_req);
    check("tag_idx",  bus.tag_idx,  m_req ? hd[IDX_W-1:0] : '0);
    check("inv_we",   bus.inv_we,   m_inv ? m_mask : '0);
    check("inv_idx",  bus.inv_idx,  m_inv ? hd[IDX_W-1:0] : '0);
    check("busy",     bus.busy,     exp_q.size() != 0);
    check("overflow", bus.overflow, m_ovf);
    // observations of the DUT for scenario-level checks
    if (bus.tag_req && first_req_cyc < 0) first_req_cyc = cyc;
    if (bus.tag_req && g) begin n_lookups++; grant_idx_q.push_back(bus.tag_idx); end
    if (bus.tag_req && !g) req_wait++;
    if (bus.inv_we != '0) begin
      inv_cnt++; inv_cyc = cyc; inv_val = bus.inv_we; inv_idx_val = bus.inv_idx;
    end
    // model advance for this clock edge
    rd_mask = m_rd ? cache_mask(hd) : '0;
    pop     = (m_rd && rd_mask == '0) || m_inv;
    if (m_inv)
      for (int w = 0; w < WAYS; w++) if (m_mask[w]) cvalid[hd[IDX_W-1:0]][w] = 1'b0;
    line   = a[31:OFFSET_W];
    sz0    = exp_q.size();
    remain = (sz0 > 1) || (sz0 == 1 && !pop);
    dup    = 1'b0;
`ifdef SNOOP_COALESCE_EN
    if (v && remain && exp_q[sz0-1] == line) dup = 1'b1;
`endif
    pre_req = m_req; pre_rd = m_rd; pre_inv = m_inv;
    if (pre_inv) m_inv = 0;
    else if (pre_rd) begin
      m_rd = 0;
      if (rd_mask != '0) begin m_inv = 1; m_mask = rd_mask; end
    end else if (pre_req) begin
      if (g) begin m_req = 0; m_rd = 1; end
    end else if (sz0 != 0) m_req = 1;
    if (pop) void'(exp_q.pop_front());
    if (v && !dup) begin
      if (sz0 < DEPTH || pop) exp_q.push_back(line);
      else m_ovf = 1;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit g);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, g);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bus.snoop_valid = 1'b0;
    bus.snoop_addr  = '0;
    bus.tag_gnt     = 1'b0;
    bus.tag_rdata   = '0;
    clear_cache();
    clear_stats();
    #1;
    do_reset();

    // Hit in way 1 with immediate grant.
    clear_cache();
    ctag[6'h23][1] = TAG_W'(4); cvalid[6'h23][1] = 1'b1;
    ctag[6'h23][0] = TAG_W'(5); cvalid[6'h23][0] = 1'b1;
    clear_stats();
    step(1'b1, 32'h0000_1230, 1'b1);
    idle(8, 1'b1);
    check("hit_inv_we",  inv_val, 2'b10);
    check("hit_inv_idx", inv_idx_val, 6'h23);
    check("hit_latency", 32'(inv_cyc - first_req_cyc), 2);
    check("hit_pulses",  inv_cnt, 1);

    // Miss in both ways.
    clear_stats();
    ctag[6'h27][0] = TAG_W'(3); cvalid[6'h27][0] = 1'b1;
    ctag[6'h27][1] = TAG_W'(8'h15); cvalid[6'h27][1] = 1'b0;
    step(1'b1, 32'h0000_5670, 1'b1);
    idle(6, 1'b1);
    check("miss_pulses",  inv_cnt, 0);
    check("miss_lookups", n_lookups, 1);
    check("miss_busy",    bus.busy, 0);

    // Grant withheld for 5 request cycles.
    clear_stats();
    ctag[6'h24][0] = TAG_W'(4'hA); cvalid[6'h24][0] = 1'b1;
    step(1'b1, 32'h0000_2A40, 1'b0);
    idle(6, 1'b0);
    idle(6, 1'b1);
    check("gnt_wait_cycles", req_wait, 5);
    check("gnt_inv_we",      inv_val, 2'b01);
    check("gnt_inv_idx",     inv_idx_val, 6'h24);

    // Six back-to-back snoops while the tag port is busy.
    do_reset();
    random_cache();
    clear_stats();
    for (int i = 0; i < 6; i++) step(1'b1, 32'h0001_0000 + 32'(i) * 32'h10, 1'b0);
    check("ovf_set", bus.overflow, 1);
    idle(30, 1'b1);
    check("ovf_lookups", grant_idx_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_idx_q.size(); i++)
      check("ovf_order", grant_idx_q[i], i);
    check("ovf_sticky", bus.overflow, 1);

    // Push while full in the same cycle as the INV pop.
    do_reset();
    clear_cache();
    for (int i = 8; i < 13; i++) begin ctag[i][0] = TAG_W'(1); cvalid[i][0] = 1'b1; end
    clear_stats();
    for (int i = 8; i < 12; i++) step(1'b1, {22'(1), 6'(i), 4'h0}, 1'b0);
    for (int k = 0; k < 10 && !m_inv; k++) step(1'b0, 32'h0, 1'b1);
    check("full_wait_inv", m_inv, 1);
    step(1'b1, {22'(1), 6'(12), 4'h0}, 1'b1);
    idle(30, 1'b1);
    check("full_ovf",     bus.overflow, 0);
    check("full_lookups", n_lookups, 5);
    check("full_pulses",  inv_cnt, 5);

    // Same line twice in a row.
    do_reset();
    clear_cache();
    clear_stats();
    step(1'b1, 32'h0000_0040, 1'b1);
    step(1'b1, 32'h0000_0044, 1'b1);
    idle(12, 1'b1);
`ifdef SNOOP_COALESCE_EN
    check("dup_lookups", n_lookups, 1);
`else
    check("dup_lookups", n_lookups, 2);
`endif
    check("dup_ovf", bus.overflow, 0);

    // Reset in the middle of a hitting lookup: no invalidate afterwards.
    clear_cache();
    ctag[6'h05][1] = TAG_W'(2); cvalid[6'h05][1] = 1'b1;
    clear_stats();
    step(1'b1, {22'(2), 6'h05, 4'h0}, 1'b1);
    step(1'b1, {22'(2), 6'h06, 4'h0}, 1'b1);
    for (int k = 0; k < 10 && !m_rd; k++) step(1'b0, 32'h0, 1'b1);
    check("midrst_wait_cmp", m_rd, 1);
    do_reset();
    clear_stats();
    idle(8, 1'b1);
    check("midrst_pulses",  inv_cnt, 0);
    check("midrst_lookups", n_lookups, 0);

    // Randomized traffic: light load, then heavy load.
    random_cache();
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 99) < 15), rand_addr(), 1'($urandom_range(0, 99) < 70));
    idle(30, 1'b1);
    check("rand_light_busy", bus.busy, 0);
    random_cache();
    for (int k = 0; k < 600; k++)
      step(1'($urandom_range(0, 99) < 50), rand_addr(), 1'($urandom_range(0, 99) < 60));
    idle(40, 1'b1);
    check("rand_heavy_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
